// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the stream demultiplexer.
// Default widths plus a clog2 used to size the destination select.
package stream_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++)
      if ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NUM   = 2;
  localparam int DEF_SEL_W = clog2(DEF_NUM);
  localparam int DEF_CNT_W = 8;

  localparam logic [DEF_CNT_W-1:0] DROP_SAT = '1;

endpackage

// File: rtl/stream_demux_if.sv
// Producer-side and consumer-side signals of the demux.
// master drives the input beat and consumer readies.
interface stream_demux_if
  import stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM   = DEF_NUM,
  parameter int SEL_W = DEF_SEL_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic                 in_valid;
  logic                 in_ready;
  logic [SEL_W-1:0]     in_sel;
  logic [WIDTH-1:0]     in_data;
  logic [NUM-1:0]       out_valid;
  logic [NUM-1:0]       out_ready;
  logic [NUM*WIDTH-1:0] out_data;
  logic [CNT_W-1:0]     drop_cnt;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, drop_cnt
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, drop_cnt
  );

endinterface

// File: rtl/stream_demux_slot.sv
// One-entry output slot: data register plus full flag.
// A load wins over a drain so a slot can stream one beat per cycle.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_drain,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else begin
      if (i_load)
        r_full <= 1'b1;
      else if (i_drain)
        r_full <= 1'b0;
      if (i_load)
        r_data <= i_data;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/stream_demux.sv
// 1-to-NUM valid/ready demux with a register slot per output.
// Out-of-range selects are swallowed and counted.
module stream_demux
  import stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM   = DEF_NUM,
  parameter int SEL_W = clog2(NUM),
  parameter int CNT_W = DEF_CNT_W
) (
  input logic           clk,
  input logic           rst,
  stream_demux_if.slave bus
);

  logic [NUM-1:0]       w_hit;
  logic [NUM-1:0]       w_load;
  logic [NUM-1:0]       w_drain;
  logic [NUM-1:0]       w_full;
  logic [NUM*WIDTH-1:0] w_data;
  logic                 w_in_range;
  logic                 w_tgt_rdy;
  logic                 w_acc;
  logic [CNT_W-1:0]     r_drop;

  genvar i;
  generate
    for (i = 0; i < NUM; i++) begin : g_slot
      assign w_hit[i]   = (bus.in_sel == SEL_W'(i));
      assign w_load[i]  = w_acc & w_hit[i];
      assign w_drain[i] = w_full[i] & bus.out_ready[i];

      demux_slot #(.WIDTH(WIDTH)) u_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load[i]),
        .i_drain (w_drain[i]),
        .i_data  (bus.in_data),
        .o_full  (w_full[i]),
        .o_data  (w_data[i*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // Only the addressed slot gates the input: head-of-line blocking.
  assign w_in_range = |w_hit;
  assign w_tgt_rdy  = |(w_hit & (~w_full | bus.out_ready));
  assign w_acc      = bus.in_valid & bus.in_ready;

  assign bus.in_ready  = !w_in_range || w_tgt_rdy;
  assign bus.out_valid = w_full;
  assign bus.out_data  = w_data;
  assign bus.drop_cnt  = r_drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_drop <= '0;
    else if (w_acc && !w_in_range && (r_drop != {CNT_W{1'b1}}))
      r_drop <= r_drop + CNT_W'(1);
  end

endmodule

// File: tb/tb_stream_demux.sv
// Directed and randomized checks of stream_demux.
// Two instances: NUM=2 for routing, NUM=3 for out-of-range drops.
module tb_stream_demux;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  stream_demux_if #(.WIDTH(8), .NUM(2), .SEL_W(1), .CNT_W(8)) b2 ();
  stream_demux_if #(.WIDTH(8), .NUM(3), .SEL_W(2), .CNT_W(8)) b3 ();

  stream_demux #(.WIDTH(8), .NUM(2), .SEL_W(1), .CNT_W(8)) u2 (
    .clk (clk),
    .rst (rst),
    .bus (b2.slave)
  );

  stream_demux #(.WIDTH(8), .NUM(3), .SEL_W(2), .CNT_W(8)) u3 (
    .clk (clk),
    .rst (rst),
    .bus (b3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] prev;
  logic       hold;
  logic       exp_rdy;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    b2.in_valid  = 1'b0;
    b2.in_sel    = '0;
    b2.in_data   = '0;
    b2.out_ready = '0;
    b3.in_valid  = 1'b0;
    b3.in_sel    = '0;
    b3.in_data   = '0;
    b3.out_ready = '0;

    // reset state
    @(negedge clk);
    chk("rst_valid", b2.out_valid, 0);
    chk("rst_data", b2.out_data, 0);
    chk("rst_drop", b3.drop_cnt, 0);
    chk("rst_valid3", b3.out_valid, 0);
    @(negedge clk);
    rst = 1'b1;

    // route sel 1
    @(negedge clk);
    b2.out_ready = 2'b11;
    b2.in_valid  = 1'b1;
    b2.in_sel    = 1'b1;
    b2.in_data   = 8'hA5;
    #1 chk("route_rdy", b2.in_ready, 1);
    @(negedge clk);
    b2.in_valid = 1'b0;
    chk("route_valid", b2.out_valid, 2'b10);
    chk("route_d1", b2.out_data[15:8], 8'hA5);
    chk("route_d0", b2.out_data[7:0], 8'h00);
    @(negedge clk);
    chk("route_drain", b2.out_valid, 2'b00);
    chk("route_hold", b2.out_data[15:8], 8'hA5);

    // backpressure / head-of-line
    b2.out_ready = 2'b00;
    b2.in_valid  = 1'b1;
    b2.in_sel    = 1'b0;
    b2.in_data   = 8'h11;
    #1 chk("bp_rdy0", b2.in_ready, 1);
    @(negedge clk);
    chk("bp_valid", b2.out_valid, 2'b01);
    chk("bp_d0", b2.out_data[7:0], 8'h11);
    b2.in_data = 8'h22;
    #1 chk("bp_stall", b2.in_ready, 0);
    @(negedge clk);
    chk("bp_hol_rdy", b2.in_ready, 0);
    chk("bp_hol_valid", b2.out_valid, 2'b01);
    chk("bp_hol_d0", b2.out_data[7:0], 8'h11);
    b2.out_ready = 2'b01;
    #1 chk("bp_release", b2.in_ready, 1);
    @(negedge clk);
    chk("bp_valid2", b2.out_valid, 2'b01);
    chk("bp_d0_2", b2.out_data[7:0], 8'h22);

    // back-to-back throughput on slot 0
    prev = 8'h22;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) @(negedge clk);
      chk("tp_valid", b2.out_valid, 2'b01);
      chk("tp_data", b2.out_data[7:0], prev);
      b2.in_data = 8'(k);
      #1 chk("tp_rdy", b2.in_ready, 1);
      prev = 8'(k);
    end
    @(negedge clk);
    chk("tp_last", b2.out_data[7:0], 8'h10);
    chk("tp_last_v", b2.out_valid, 2'b01);
    b2.in_valid = 1'b0;
    @(negedge clk);
    chk("tp_empty", b2.out_valid, 2'b00);

    // NUM=3: route sel 2, then drop sel 3
    b3.out_ready = 3'b111;
    b3.in_valid  = 1'b1;
    b3.in_sel    = 2'd2;
    b3.in_data   = 8'h3C;
    @(negedge clk);
    chk("n3_valid", b3.out_valid, 3'b100);
    chk("n3_data", b3.out_data[23:16], 8'h3C);
    b3.in_sel  = 2'd3;
    b3.in_data = 8'hEE;
    for (int j = 0; j < 300; j++) begin
      if (j > 0) @(negedge clk);
      if (j > 0) chk("drop_nov", b3.out_valid, 0);
      chk("drop_cnt", b3.drop_cnt, (j < 255) ? j : 255);
      #1 chk("drop_rdy", b3.in_ready, 1);
    end
    @(negedge clk);
    b3.in_valid = 1'b0;
    chk("drop_sat", b3.drop_cnt, 255);
    chk("drop_nov_end", b3.out_valid, 0);

    // random traffic against per-output scoreboards
    hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      chk("rnd_v0", b2.out_valid[0], q0.size() > 0);
      chk("rnd_v1", b2.out_valid[1], q1.size() > 0);
      if (q0.size() > 0) chk("rnd_d0", b2.out_data[7:0], q0[0]);
      if (q1.size() > 0) chk("rnd_d1", b2.out_data[15:8], q1[0]);
      if (!hold) begin
        b2.in_valid = 1'($urandom_range(0, 1));
        b2.in_sel   = 1'($urandom_range(0, 1));
        b2.in_data  = 8'($urandom);
      end
      b2.out_ready = 2'($urandom_range(0, 3));
      #1;
      if (b2.in_sel)
        exp_rdy = (q1.size() == 0) || b2.out_ready[1];
      else
        exp_rdy = (q0.size() == 0) || b2.out_ready[0];
      chk("rnd_rdy", b2.in_ready, exp_rdy);
      if (q0.size() > 0 && b2.out_ready[0]) void'(q0.pop_front());
      if (q1.size() > 0 && b2.out_ready[1]) void'(q1.pop_front());
      if (b2.in_valid && exp_rdy) begin
        if (b2.in_sel) q1.push_back(b2.in_data);
        else           q0.push_back(b2.in_data);
      end
      hold = b2.in_valid && !exp_rdy;
    end
    @(negedge clk);
    b2.in_valid  = 1'b0;
    b2.out_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("rnd_flush", b2.out_valid, 2'b00);

    // async reset mid-stream with slot 1 full
    b2.out_ready = 2'b00;
    b2.in_valid  = 1'b1;
    b2.in_sel    = 1'b1;
    b2.in_data   = 8'h5A;
    @(negedge clk);
    b2.in_valid = 1'b0;
    chk("mrst_pre", b2.out_valid, 2'b10);
    chk("mrst_pre_d", b2.out_data[15:8], 8'h5A);
    #2 rst = 1'b0;
    #1;
    chk("mrst_valid", b2.out_valid, 0);
    chk("mrst_data", b2.out_data, 0);
    chk("mrst_drop", b3.drop_cnt, 0);
    chk("mrst_data3", b3.out_data, 0);
    @(negedge clk);
    chk("mrst_hold", b2.out_valid, 0);
    rst = 1'b1;
    b2.out_ready = 2'b11;
    @(negedge clk);
    chk("mrst_gone", b2.out_valid, 0);
    chk("mrst_gone_d", b2.out_data, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
